uart_tx: RTL

//  - 8N1 UART transmitter with shallow TX FIFO; outbound counterpart of the boot/loader UART receiver.
//  - Core writes bytes (memory-mapped result or debug output); block serialises them LSB-first on tx_serial.
//  - Raises tx_done per finished frame, same pulse style as recv_done on the receive side.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_fifo.sv | 62 ++++++
 rtl/uart_tx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
// Holds the serializer state encoding, the bit-period helper and frame constants.
package uart_pkg;

    // Serializer / deserializer states; PARITY is only entered when parity is enabled
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int DATA_BITS         = 8;
    localparam int FRAME_BITS_8N1    = 10;
    localparam int FRAME_BITS_PARITY = 11;

    // Clock cycles per bit on the line; truncating divide
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small synchronous FIFO feeding the UART serializer.
// DEPTH must be a power of two so the pointers wrap naturally.
// Pushes while full and pops while empty are ignored; full/empty come from the registered count.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a shallow TX FIFO, LSB first, idle-high line.
// Define UART_TX_PARITY_EN to append an even parity bit after the data bits (8E1).
// Back-to-back bytes are sent with no idle gap: the next byte is popped on the last stop cycle.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_wr,
    input  logic [7:0] tx_data,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_overflow,
    output logic       tx_serial
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    uart_state_t      state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shifter;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit;
`endif
    logic             baud_end;
    logic             fifo_pop;
    logic             fifo_empty;
    logic [7:0]       fifo_head;

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign fifo_pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_end));
    assign tx_empty = fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (tx_wr),
        .pop     (fifo_pop),
        .wr_data (tx_data),
        .rd_data (fifo_head),
        .full    (tx_full),
        .empty   (fifo_empty)
    );

    // Serializer FSM: baud counter, bit index, shift register and registered line/status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shifter   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (!fifo_empty) begin
                        shifter    <= fifo_head;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^fifo_head;
`endif
                        state      <= START;
                        tx_serial  <= 1'b0;
                        tx_busy    <= 1'b1;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt  <= '0;
                        state     <= DATA;
                        tx_serial <= shifter[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == LAST_BIT) begin
                            bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
                            state     <= PARITY;
                            tx_serial <= parity_bit;
`else
                            state     <= STOP;
                            tx_serial <= 1'b1;
`endif
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shifter   <= {1'b0, shifter[7:1]};
                            tx_serial <= shifter[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        baud_cnt  <= '0;
                        state     <= STOP;
                        tx_serial <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        tx_done  <= 1'b1;
                        if (!fifo_empty) begin
                            shifter    <= fifo_head;
`ifdef UART_TX_PARITY_EN
                            parity_bit <= ^fifo_head;
`endif
                            state      <= START;
                            tx_serial  <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            tx_serial <= 1'b1;
                            tx_busy   <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    baud_cnt  <= '0;
                    tx_serial <= 1'b1;
                    tx_busy   <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow flag: set whenever a write arrives while the FIFO is full
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_overflow <= 1'b0;
        end else if (tx_wr && tx_full) begin
            tx_overflow <= 1'b1;
        end
    end

endmodule
